laser_rate_monitor: RTL and testbench

LASER_RATE_MONITOR -- requirements
Module: laser_rate_monitor

---
 rtl/laser_rate_monitor.sv | 190 +++++++++++++++++++
 tb/tb_laser_rate_monitor.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_rate_monitor.sv
// ---------------------------------------------------------------------------
// laser_rate_monitor
//
// Watches the pulse-rate samples from an upstream rate counter. It keeps a
// moving average over the last 8 samples, a saturating sample count, and
// optional min/max tracking. A small FSM raises under-range or over-range
// alarms only after a run of 3 consecutive samples of the same class.
//
// Compile-time option:
//   RATE_MON_MINMAX_EN  defined   -> MinRate/MaxRate track min/max samples
//                       undefined -> MinRate/MaxRate are tied to 0 and have
//                                    no registers behind them
//
// Ports:
//   Clk          system clock (50 MHz)
//   Reset        asynchronous, active-high reset
//   Rate         new rate sample (pulses per second)
//   RateValid    one-cycle strobe that qualifies Rate
//   LowThresh    lower in-range limit (inclusive)
//   HighThresh   upper in-range limit (inclusive)
//   ClearStats   synchronous clear; wins over a simultaneous RateValid
//   AvgRate      mean of the last 8 samples (sum >> 3)
//   AvgValid     high once 8 samples have been accepted
//   MinRate      minimum sample since reset/clear
//   MaxRate      maximum sample since reset/clear
//   SampleCount  samples accepted, saturating at 65535
//   AlarmLow     qualified under-range alarm
//   AlarmHigh    qualified over-range alarm
// ---------------------------------------------------------------------------
module laser_rate_monitor (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Rate,
  input  logic        RateValid,
  input  logic [31:0] LowThresh,
  input  logic [31:0] HighThresh,
  input  logic        ClearStats,
  output logic [31:0] AvgRate,
  output logic        AvgValid,
  output logic [31:0] MinRate,
  output logic [31:0] MaxRate,
  output logic [15:0] SampleCount,
  output logic        AlarmLow,
  output logic        AlarmHigh
);

  typedef enum logic [1:0] {ST_EMPTY, ST_OK, ST_LOW, ST_HIGH} state_t;
  typedef enum logic [1:0] {CLS_IN, CLS_LOW, CLS_HIGH} class_t;

  logic [31:0] win_q [8];
  logic [31:0] win_d [8];
  logic [2:0]  wr_ptr_q, wr_ptr_d;
  logic [34:0] sum_q, sum_d;
  logic [15:0] count_q, count_d;
  logic        avg_valid_q, avg_valid_d;
  state_t      state_q, state_d;
  class_t      cls_q, cls_d;
  logic [1:0]  run_q, run_d;

  logic [31:0] evicted;
  logic        thresh_ok;
  class_t      cls_now;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    win_d       = win_q;
    wr_ptr_d    = wr_ptr_q;
    sum_d       = sum_q;
    count_d     = count_q;
    avg_valid_d = avg_valid_q;
    state_d     = state_q;
    cls_d       = cls_q;
    run_d       = run_q;

    // Until the window has filled once, the slot being overwritten has never
    // been part of the sum, so it contributes nothing.
    evicted   = avg_valid_q ? win_q[wr_ptr_q] : 32'd0;
    thresh_ok = (LowThresh <= HighThresh);

    // Invalid thresholds classify everything as in-range, which keeps the
    // FSM in OK and both alarms low.
    if (!thresh_ok)              cls_now = CLS_IN;
    else if (Rate < LowThresh)   cls_now = CLS_LOW;
    else if (Rate > HighThresh)  cls_now = CLS_HIGH;
    else                         cls_now = CLS_IN;

    if (ClearStats) begin
      win_d       = '{default: '0};
      wr_ptr_d    = '0;
      sum_d       = '0;
      count_d     = '0;
      avg_valid_d = 1'b0;
      state_d     = ST_EMPTY;
      cls_d       = CLS_IN;
      run_d       = '0;
    end else if (RateValid) begin
      win_d[wr_ptr_q] = Rate;
      wr_ptr_d        = wr_ptr_q + 3'd1;  // 3-bit pointer wraps 7 -> 0
      sum_d           = sum_q + {3'b000, Rate} - {3'b000, evicted};
      count_d         = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
      if (wr_ptr_q == 3'd7) avg_valid_d = 1'b1;

      // Run length of identical classes, saturating at 3.
      if (state_q == ST_EMPTY || cls_now != cls_q) run_d = 2'd1;
      else if (run_q != 2'd3)                       run_d = run_q + 2'd1;
      cls_d = cls_now;

      if (!thresh_ok)                state_d = ST_OK;
      else if (run_d == 2'd3) begin
        case (cls_now)
          CLS_LOW:  state_d = ST_LOW;
          CLS_HIGH: state_d = ST_HIGH;
          default:  state_d = ST_OK;
        endcase
      end else if (state_q == ST_EMPTY) state_d = ST_OK;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others.
  // NOTE: the sample window is reset along with the rest so a reset or
  // clear always starts from a known-empty buffer.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      win_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      sum_q       <= '0;
      count_q     <= '0;
      avg_valid_q <= 1'b0;
      state_q     <= ST_EMPTY;
      cls_q       <= CLS_IN;
      run_q       <= '0;
    end else begin
      win_q       <= win_d;
      wr_ptr_q    <= wr_ptr_d;
      sum_q       <= sum_d;
      count_q     <= count_d;
      avg_valid_q <= avg_valid_d;
      state_q     <= state_d;
      cls_q       <= cls_d;
      run_q       <= run_d;
    end
  end

  assign AvgRate     = sum_q[34:3];
  assign AvgValid    = avg_valid_q;
  assign SampleCount = count_q;
  assign AlarmLow    = (state_q == ST_LOW);
  assign AlarmHigh   = (state_q == ST_HIGH);

`ifdef RATE_MON_MINMAX_EN
  logic [31:0] min_q, min_d, max_q, max_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (ClearStats) begin
      min_d = '0;
      max_d = '0;
    end else if (RateValid) begin
      // The first sample since reset/clear seeds both trackers.
      if (count_q == 16'd0) begin
        min_d = Rate;
        max_d = Rate;
      end else begin
        if (Rate < min_q) min_d = Rate;
        if (Rate > max_q) max_d = Rate;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      min_q <= '0;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign MinRate = min_q;
  assign MaxRate = max_q;
`else
  assign MinRate = 32'd0;
  assign MaxRate = 32'd0;
`endif

endmodule

// File: tb/tb_laser_rate_monitor.sv
// ---------------------------------------------------------------------------
// tb_laser_rate_monitor
//
// Directed scenarios plus a randomized run, all checked against a reference
// model that keeps the accepted samples in a queue and derives the average,
// count, min/max and alarm state directly from that sample history.
// ---------------------------------------------------------------------------
module tb_laser_rate_monitor;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] Rate;
  logic        RateValid;
  logic [31:0] LowThresh;
  logic [31:0] HighThresh;
  logic        ClearStats;
  logic [31:0] AvgRate;
  logic        AvgValid;
  logic [31:0] MinRate;
  logic [31:0] MaxRate;
  logic [15:0] SampleCount;
  logic        AlarmLow;
  logic        AlarmHigh;

  int n_checks = 0;
  int n_errors = 0;

  laser_rate_monitor dut (
    .Clk(Clk), .Reset(Reset), .Rate(Rate), .RateValid(RateValid),
    .LowThresh(LowThresh), .HighThresh(HighThresh), .ClearStats(ClearStats),
    .AvgRate(AvgRate), .AvgValid(AvgValid), .MinRate(MinRate),
    .MaxRate(MaxRate), .SampleCount(SampleCount),
    .AlarmLow(AlarmLow), .AlarmHigh(AlarmHigh)
  );

  always #10 Clk = ~Clk;

  // ---------------- reference model ----------------
  // m_state: 0 = empty, 1 = ok, 2 = low alarm, 3 = high alarm
  int unsigned win[$];
  int          cls_hist[$];
  int unsigned m_total;
  int unsigned m_min, m_max;
  int          m_state;

  function automatic void model_clear();
    win.delete();
    cls_hist.delete();
    m_total = 0;
    m_min   = 0;
    m_max   = 0;
    m_state = 0;
  endfunction

  function automatic void model_accept(int unsigned r, int unsigned lo, int unsigned hi);
    int c;
    if (m_total == 0) begin
      m_min = r;
      m_max = r;
    end else begin
      if (r < m_min) m_min = r;
      if (r > m_max) m_max = r;
    end
    m_total++;
    win.push_back(r);
    if (win.size() > 8) void'(win.pop_front());
    c = (lo > hi) ? 0 : (r < lo) ? 1 : (r > hi) ? 2 : 0;
    cls_hist.push_back(c);
    if (cls_hist.size() > 3) void'(cls_hist.pop_front());
    if (lo > hi) m_state = 1;
    else if (cls_hist.size() == 3 && cls_hist[0] == c && cls_hist[1] == c)
      m_state = (c == 1) ? 2 : (c == 2) ? 3 : 1;
    else if (m_state == 0) m_state = 1;
  endfunction

  function automatic logic [31:0] exp_avg();
    longint unsigned s = 0;
    foreach (win[i]) s += win[i];
    return 32'(s / 8);
  endfunction

  function automatic logic [15:0] exp_count();
    return (m_total > 65535) ? 16'hFFFF : 16'(m_total);
  endfunction

  function automatic logic [31:0] exp_min();
`ifdef RATE_MON_MINMAX_EN
    return m_min;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_max();
`ifdef RATE_MON_MINMAX_EN
    return m_max;
`else
    return 32'd0;
`endif
  endfunction

  // One clock of stimulus: inputs applied at a falling edge, held across the
  // rising edge, and outputs are observed at the next falling edge.
  task automatic drive(input logic v, input logic [31:0] r, input logic c);
    Rate = r;
    RateValid = v;
    ClearStats = c;
    if (c) model_clear();
    else if (v) model_accept(r, LowThresh, HighThresh);
    @(negedge Clk);
    RateValid = 1'b0;
    ClearStats = 1'b0;
  endtask

  task automatic do_clear();
    drive(1'b0, 32'd0, 1'b1);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    n_checks++;
    if (AvgRate !== 0 || AvgValid !== 0 || MinRate !== 0 || MaxRate !== 0 ||
        SampleCount !== 0 || AlarmLow !== 0 || AlarmHigh !== 0) begin
      n_errors++;
      $display("FAIL reset_outputs: avg=%0d vld=%0b min=%0d max=%0d cnt=%0d al=%0b ah=%0b, expected all 0",
               AvgRate, AvgValid, MinRate, MaxRate, SampleCount, AlarmLow, AlarmHigh);
    end
    Reset = 1'b0;
    model_clear();
    @(negedge Clk);
  endtask

  task automatic test_avg_fill();
    do_clear();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'd1000, 1'b0);
      n_checks++;
      if (AvgValid !== (i == 8)) begin
        n_errors++;
        $display("FAIL fill_avgvalid[%0d]: got %0b expected %0b", i, AvgValid, (i == 8));
      end
    end
    n_checks++;
    if (AvgRate !== 32'd1000 || SampleCount !== 16'd8) begin
      n_errors++;
      $display("FAIL fill_avg: avg=%0d cnt=%0d expected avg=1000 cnt=8", AvgRate, SampleCount);
    end
  endtask

  task automatic test_wrap();
    do_clear();
    repeat (8) drive(1'b1, 32'd1000, 1'b0);
    drive(1'b1, 32'd2000, 1'b0);
    n_checks++;
    if (AvgRate !== 32'd1125) begin
      n_errors++;
      $display("FAIL wrap_sample9: avg=%0d expected 1125", AvgRate);
    end
    repeat (7) drive(1'b1, 32'd2000, 1'b0);
    n_checks++;
    if (AvgRate !== 32'd2000 || SampleCount !== 16'd16) begin
      n_errors++;
      $display("FAIL wrap_sample16: avg=%0d cnt=%0d expected avg=2000 cnt=16", AvgRate, SampleCount);
    end
  endtask

  task automatic test_alarm();
    logic [31:0] seq [7];
    logic        exp_h [7];
    seq   = '{32'd1000, 32'd1200, 32'd1200, 32'd1200, 32'd1000, 32'd1000, 32'd1000};
    exp_h = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    LowThresh  = 32'd900;
    HighThresh = 32'd1100;
    do_clear();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, seq[i], 1'b0);
      n_checks++;
      if (AlarmHigh !== exp_h[i] || AlarmLow !== 1'b0) begin
        n_errors++;
        $display("FAIL alarm_high[%0d]: ah=%0b al=%0b expected ah=%0b al=0", i, AlarmHigh, AlarmLow, exp_h[i]);
      end
    end
    // Low alarm after three under-range samples.
    repeat (3) drive(1'b1, 32'd500, 1'b0);
    n_checks++;
    if (AlarmLow !== 1'b1 || AlarmHigh !== 1'b0) begin
      n_errors++;
      $display("FAIL alarm_low: al=%0b ah=%0b expected al=1 ah=0", AlarmLow, AlarmHigh);
    end
    // Threshold change with no sample must not move the FSM.
    LowThresh = 32'd0;
    repeat (2) drive(1'b0, 32'd0, 1'b0);
    n_checks++;
    if (AlarmLow !== 1'b1) begin
      n_errors++;
      $display("FAIL alarm_no_retro: al=%0b expected 1", AlarmLow);
    end
    // Invalid thresholds: next accepted sample forces OK.
    LowThresh  = 32'd2000;
    HighThresh = 32'd1000;
    drive(1'b1, 32'd500, 1'b0);
    n_checks++;
    if (AlarmLow !== 1'b0 || AlarmHigh !== 1'b0) begin
      n_errors++;
      $display("FAIL alarm_invalid_thresh: al=%0b ah=%0b expected 0 0", AlarmLow, AlarmHigh);
    end
  endtask

  task automatic test_clear_collision();
    LowThresh  = 32'd900;
    HighThresh = 32'd1100;
    do_clear();
    repeat (9) drive(1'b1, 32'd500, 1'b0);  // AlarmLow active, window full
    drive(1'b1, 32'd777, 1'b1);             // clear wins, sample discarded
    n_checks++;
    if (SampleCount !== 0 || AvgValid !== 0 || AvgRate !== 0 || AlarmLow !== 0 || AlarmHigh !== 0) begin
      n_errors++;
      $display("FAIL clear_collision: cnt=%0d vld=%0b avg=%0d al=%0b ah=%0b expected all 0",
               SampleCount, AvgValid, AvgRate, AlarmLow, AlarmHigh);
    end
    // FSM restarted from EMPTY: a low run needs 3 fresh samples again.
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 32'd500, 1'b0);
      n_checks++;
      if (AlarmLow !== (i == 3) || SampleCount !== 16'(i)) begin
        n_errors++;
        $display("FAIL clear_restart[%0d]: al=%0b cnt=%0d expected al=%0b cnt=%0d",
                 i, AlarmLow, SampleCount, (i == 3), i);
      end
    end
  endtask

  task automatic test_overflow_reset();
    LowThresh  = 32'd0;
    HighThresh = 32'hFFFF_FFFF;
    do_clear();
    repeat (9) drive(1'b1, 32'hFFFF_FFFF, 1'b0);
    n_checks++;
    if (AvgRate !== 32'hFFFF_FFFF || AvgValid !== 1'b1) begin
      n_errors++;
      $display("FAIL overflow_avg: avg=%h vld=%0b expected ffffffff 1", AvgRate, AvgValid);
    end
    drive(1'b1, 32'd16, 1'b0);
    #3 Reset = 1'b1;  // asynchronous, away from any clock edge
    #1;
    model_clear();
    n_checks++;
    if (AvgRate !== 0 || AvgValid !== 0 || MinRate !== 0 || MaxRate !== 0 ||
        SampleCount !== 0 || AlarmLow !== 0 || AlarmHigh !== 0) begin
      n_errors++;
      $display("FAIL midstream_reset: avg=%0d vld=%0b min=%0d max=%0d cnt=%0d, expected all 0",
               AvgRate, AvgValid, MinRate, MaxRate, SampleCount);
    end
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    drive(1'b1, 32'd80, 1'b0);
    n_checks++;
    if (SampleCount !== 16'd1 || AvgRate !== 32'd10 || AvgValid !== 1'b0) begin
      n_errors++;
      $display("FAIL after_reset_first: cnt=%0d avg=%0d vld=%0b expected 1 10 0", SampleCount, AvgRate, AvgValid);
    end
  endtask

  task automatic test_minmax();
    logic [31:0] e_min, e_max;
    do_clear();
    drive(1'b1, 32'd5, 1'b0);
    drive(1'b1, 32'd3, 1'b0);
    drive(1'b1, 32'd9, 1'b0);
`ifdef RATE_MON_MINMAX_EN
    e_min = 32'd3;
    e_max = 32'd9;
`else
    e_min = 32'd0;
    e_max = 32'd0;
`endif
    n_checks++;
    if (MinRate !== e_min || MaxRate !== e_max) begin
      n_errors++;
      $display("FAIL minmax: min=%0d max=%0d expected %0d %0d", MinRate, MaxRate, e_min, e_max);
    end
  endtask

  task automatic test_back_to_back_saturate();
    do_clear();
    Rate = 32'd7;
    RateValid = 1'b1;
    for (int i = 0; i < 65540; i++) model_accept(32'd7, LowThresh, HighThresh);
    repeat (65540) @(negedge Clk);
    RateValid = 1'b0;
    n_checks++;
    if (SampleCount !== exp_count() || AvgRate !== exp_avg()) begin
      n_errors++;
      $display("FAIL count_saturate: cnt=%0d avg=%0d expected %0d %0d", SampleCount, AvgRate, exp_count(), exp_avg());
    end
  endtask

  task automatic test_random();
    logic        v, c;
    logic [31:0] r;
    do_clear();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 4) == 0) begin
          HighThresh = $urandom_range(950, 1050);
          LowThresh  = HighThresh + 32'd50;
        end else begin
          LowThresh  = $urandom_range(850, 1000);
          HighThresh = $urandom_range(1000, 1150);
        end
      end
      c = ($urandom_range(0, 29) == 0);
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 19) == 0) ? $urandom : $urandom_range(800, 1200);
      drive(v, r, c);
      n_checks++;
      if (AvgRate !== exp_avg() || AvgValid !== (win.size() == 8) ||
          SampleCount !== exp_count() || MinRate !== exp_min() || MaxRate !== exp_max() ||
          AlarmLow !== (m_state == 2) || AlarmHigh !== (m_state == 3)) begin
        n_errors++;
        $display("FAIL random[%0d]: avg=%0d/%0d vld=%0b/%0b cnt=%0d/%0d min=%0d/%0d max=%0d/%0d al=%0b/%0b ah=%0b/%0b (got/expected)",
                 i, AvgRate, exp_avg(), AvgValid, (win.size() == 8), SampleCount, exp_count(),
                 MinRate, exp_min(), MaxRate, exp_max(), AlarmLow, (m_state == 2), AlarmHigh, (m_state == 3));
      end
    end
  endtask

  initial begin
    Rate       = '0;
    RateValid  = 1'b0;
    ClearStats = 1'b0;
    LowThresh  = 32'd0;
    HighThresh = 32'hFFFF_FFFF;
    model_clear();
    @(negedge Clk);
    test_reset();
    test_avg_fill();
    test_wrap();
    test_alarm();
    test_clear_collision();
    test_overflow_reset();
    test_minmax();
    test_random();
    test_back_to_back_saturate();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
